// File: rtl/gtt_pkg.sv
// Shared types and sizes for the gate truth-table sequencer.
package gtt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SAMPLE,
    DONE
  } seq_state_t;

  localparam int NUM_VEC = 4;
  localparam int VEC_W   = 2;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that marks when a GUT input vector has settled.
module settle_timer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = $clog2(SETTLE_CYCLES + 1)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  output logic o_expired
);

  logic [CNT_W-1:0] r_cnt;

  // Load SETTLE_CYCLES-1 so the count reaches zero on the last settle cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(SETTLE_CYCLES - 1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/gate_truth_table_sequencer.sv
// Self-test sequencer for a 2-input gate: walks vectors 00..11, samples the
// gate output after a settle time and compares against an expected table.
module gate_truth_table_sequencer
  import gtt_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [NUM_VEC-1:0] i_exp_tt,
  input  logic               i_gate_y,
  output logic               o_gate_a,
  output logic               o_gate_b,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_pass,
  output logic [NUM_VEC-1:0] o_obs_tt,
  output logic [NUM_VEC-1:0] o_fail_mask
);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 1");
  end

  seq_state_t         r_state;
  seq_state_t         w_state_next;
  logic [VEC_W-1:0]   r_idx;
  logic [NUM_VEC-1:0] r_exp;
  logic [NUM_VEC-1:0] r_obs;
  logic [NUM_VEC-1:0] r_fail;
  logic               r_pass;
  logic [NUM_VEC-1:0] w_obs_next;
  logic               w_load;
  logic               w_expired;
  logic               w_accept;
  logic               w_last_vec;

  assign w_accept   = i_start && !i_abort;
  assign w_last_vec = (r_idx == VEC_W'(NUM_VEC - 1));

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (w_load),
    .o_expired(w_expired)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; abort overrides every transition outside IDLE.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    if (r_state != IDLE && i_abort) begin
      w_state_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) w_state_next = APPLY;
        end
        APPLY: begin
          w_load       = 1'b1;
          w_state_next = SETTLE;
        end
        SETTLE: begin
          if (w_expired) w_state_next = SAMPLE;
        end
        SAMPLE: begin
          w_state_next = w_last_vec ? DONE : APPLY;
        end
        DONE: begin
          w_state_next = IDLE;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Observed table including the bit captured this cycle.
  always_comb begin
    w_obs_next        = r_obs;
    w_obs_next[r_idx] = i_gate_y;
  end

  // Index and result registers. Verdict is formed as the run enters DONE so
  // pass/fail_mask are already valid while done pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx  <= '0;
      r_exp  <= '0;
      r_obs  <= '0;
      r_fail <= '0;
      r_pass <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_accept) begin
        r_idx  <= '0;
        r_exp  <= i_exp_tt;
        r_obs  <= '0;
        r_fail <= '0;
        r_pass <= 1'b0;
      end
    end else if (i_abort) begin
      // Partial samples stay visible for debug.
      r_idx  <= '0;
      r_fail <= '0;
      r_pass <= 1'b0;
    end else if (r_state == SAMPLE) begin
      r_obs <= w_obs_next;
      if (w_last_vec) begin
        r_fail <= w_obs_next ^ r_exp;
        r_pass <= (w_obs_next == r_exp);
      end else begin
        r_idx <= r_idx + VEC_W'(1);
      end
    end
  end

  // The vector index drives the GUT directly, so the last vector is held.
  always_comb begin
    o_gate_a    = r_idx[1];
    o_gate_b    = r_idx[0];
    o_busy      = (r_state == APPLY) || (r_state == SETTLE) || (r_state == SAMPLE);
    o_done      = (r_state == DONE);
    o_pass      = r_pass;
    o_obs_tt    = r_obs;
    o_fail_mask = r_fail;
  end

endmodule

// File: tb/tb_gate_truth_table_sequencer.sv
// Bench for gate_truth_table_sequencer: two instances (settle 4 and 1) checked
// every cycle against a timeline model, plus literal end-of-run expectations.
module tb_gate_truth_table_sequencer;

  localparam int S0 = 4;
  localparam int S1 = 1;

  logic       clk;
  logic       rst     [2];
  logic       start   [2];
  logic       abort   [2];
  logic [3:0] exp_tt  [2];
  logic       gate_a  [2];
  logic       gate_b  [2];
  logic       busy    [2];
  logic       done    [2];
  logic       pass    [2];
  logic [3:0] obs_tt  [2];
  logic [3:0] fail_mask [2];
  logic       gy0;
  logic       gy1;
  bit         gmode0;   // 1: OR gate, 0: output stuck at 0

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  gate_truth_table_sequencer #(.SETTLE_CYCLES(S0)) u_dut0 (
    .i_clk(clk), .i_rst(rst[0]), .i_start(start[0]), .i_abort(abort[0]),
    .i_exp_tt(exp_tt[0]), .i_gate_y(gy0), .o_gate_a(gate_a[0]), .o_gate_b(gate_b[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_pass(pass[0]), .o_obs_tt(obs_tt[0]),
    .o_fail_mask(fail_mask[0])
  );

  gate_truth_table_sequencer #(.SETTLE_CYCLES(S1)) u_dut1 (
    .i_clk(clk), .i_rst(rst[1]), .i_start(start[1]), .i_abort(abort[1]),
    .i_exp_tt(exp_tt[1]), .i_gate_y(gy1), .o_gate_a(gate_a[1]), .o_gate_b(gate_b[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_pass(pass[1]), .o_obs_tt(obs_tt[1]),
    .o_fail_mask(fail_mask[1])
  );

  // GUTs: instance 0 has a 2 ns propagation delay, instance 1 none.
  always @(gate_a[0] or gate_b[0] or gmode0) gy0 <= #2 gmode0 & (gate_a[0] | gate_b[0]);
  assign gy1 = gate_a[1] | gate_b[1];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int u, input logic [31:0] act,
                       input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s (dut%0d) at cycle %0d: got %0h, expected %0h", name, u, cyc, act, req);
    end
  endtask

  // ---------------- timeline model ----------------
  // A run is described by c = edges since the accepting edge; each vector
  // spans L = settle+2 edges, and the run ends after 4*L edges plus one.
  bit         m_act  [2];
  int         m_c    [2];
  logic [3:0] m_exp  [2];
  logic [3:0] m_obs  [2];
  logic [3:0] m_fm   [2];
  logic       m_pass [2];
  int         m_vec  [2];
  bit         m_mode [2];

  function automatic logic gut_out(input bit mode, input int k);
    return mode && (k != 0);
  endfunction

  initial begin
    for (int u = 0; u < 2; u++) begin
      m_act[u] = 0; m_c[u] = 0; m_exp[u] = '0; m_obs[u] = '0; m_fm[u] = '0;
      m_pass[u] = 1'b0; m_vec[u] = 0; m_mode[u] = 1'b1;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int u = 0; u < 2; u++) begin
        int len;
        len = (u == 0) ? S0 + 2 : S1 + 2;
        if (rst[u]) begin
          m_act[u] = 0; m_obs[u] = '0; m_fm[u] = '0; m_pass[u] = 1'b0; m_vec[u] = 0;
        end else if (m_act[u]) begin
          if (abort[u]) begin
            m_act[u] = 0; m_vec[u] = 0; m_pass[u] = 1'b0; m_fm[u] = '0;
          end else begin
            m_c[u]++;
            if (m_c[u] > 4 * len) begin
              m_act[u] = 0;
            end else begin
              if (m_c[u] % len == 0) m_obs[u][m_c[u] / len - 1] = gut_out(m_mode[u], m_c[u] / len - 1);
              m_vec[u] = (m_c[u] / len > 3) ? 3 : m_c[u] / len;
              if (m_c[u] == 4 * len) begin
                m_fm[u]   = m_obs[u] ^ m_exp[u];
                m_pass[u] = (m_obs[u] == m_exp[u]);
              end
            end
          end
        end else if (start[u] && !abort[u]) begin
          m_act[u] = 1; m_c[u] = 0; m_exp[u] = exp_tt[u]; m_obs[u] = '0; m_fm[u] = '0;
          m_pass[u] = 1'b0; m_vec[u] = 0; m_mode[u] = (u == 0) ? gmode0 : 1'b1;
        end
      end
      #1;
      for (int u = 0; u < 2; u++) begin
        int len;
        len = (u == 0) ? S0 + 2 : S1 + 2;
        check("busy", u, 32'(busy[u]), 32'(m_act[u] && m_c[u] < 4 * len));
        check("done", u, 32'(done[u]), 32'(m_act[u] && m_c[u] == 4 * len));
        check("gate_ab", u, 32'({gate_a[u], gate_b[u]}), 32'(m_vec[u]));
        check("obs_tt", u, 32'(obs_tt[u]), 32'(m_obs[u]));
        check("fail_mask", u, 32'(fail_mask[u]), 32'(m_fm[u]));
        check("pass", u, 32'(pass[u]), 32'(m_pass[u]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start(input int u, output int acc);
    @(negedge clk);
    start[u] = 1'b1;
    acc = cyc + 1;
    @(negedge clk);
    start[u] = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_done(input int u, input int acc, input int edges, input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (done[u]) seen = 1;
      else @(negedge clk);
    end
    if (seen) check(name, u, 32'(cyc - acc), 32'(edges));
    else check({name, "_timeout"}, u, 32'(0), 32'(1));
  endtask

  task automatic run_and_check(input int u, input logic [3:0] tt, input int edges,
                               input logic [3:0] obs_req, input logic [3:0] fm_req,
                               input logic pass_req, input string name);
    int acc;
    exp_tt[u] = tt;
    pulse_start(u, acc);
    wait_done(u, acc, edges, {name, "_done_edge"});
    check({name, "_obs"}, u, 32'(obs_tt[u]), 32'(obs_req));
    check({name, "_fmask"}, u, 32'(fail_mask[u]), 32'(fm_req));
    check({name, "_pass"}, u, 32'(pass[u]), 32'(pass_req));
    repeat (3) @(negedge clk);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int acc;
    int done_seen;
    gmode0 = 1'b1;
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; start[u] = 1'b0; abort[u] = 1'b0; exp_tt[u] = 4'b1110;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("reset_busy", u, 32'(busy[u]), 32'(0));
      check("reset_obs", u, 32'(obs_tt[u]), 32'(0));
      check("reset_gate", u, 32'({gate_a[u], gate_b[u]}), 32'(0));
      rst[u] = 1'b0;
    end
    @(negedge clk);

    // OR gate, OR table; also pin the vector stepping.
    exp_tt[0] = 4'b1110;
    pulse_start(0, acc);
    wait_until(acc + 7);
    check("or_vec1", 0, 32'({gate_a[0], gate_b[0]}), 32'(2'b01));
    wait_until(acc + 13);
    check("or_vec2", 0, 32'({gate_a[0], gate_b[0]}), 32'(2'b10));
    wait_done(0, acc, 24, "or_done_edge");
    check("or_obs", 0, 32'(obs_tt[0]), 32'(4'b1110));
    check("or_fmask", 0, 32'(fail_mask[0]), 32'(4'b0000));
    check("or_pass", 0, 32'(pass[0]), 32'(1));
    repeat (3) @(negedge clk);
    check("or_hold_11", 0, 32'({gate_a[0], gate_b[0]}), 32'(2'b11));

    // Stuck-at-0 gate.
    gmode0 = 1'b0;
    run_and_check(0, 4'b1110, 24, 4'b0000, 4'b1110, 1'b0, "zero");
    gmode0 = 1'b1;

    // OR gate against the AND table.
    run_and_check(0, 4'b1000, 24, 4'b1110, 4'b0110, 1'b0, "andtt");

    // Abort during SETTLE of vector 2.
    exp_tt[0] = 4'b1110;
    pulse_start(0, acc);
    wait_until(acc + 13);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    check("abort_busy", 0, 32'(busy[0]), 32'(0));
    check("abort_gate", 0, 32'({gate_a[0], gate_b[0]}), 32'(0));
    check("abort_pass", 0, 32'(pass[0]), 32'(0));
    check("abort_obs", 0, 32'(obs_tt[0]), 32'(4'b0010));
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done[0]) done_seen++;
    end
    check("abort_no_done", 0, 32'(done_seen), 32'(0));

    // Re-pulsed start and exp_tt change mid-run are ignored.
    exp_tt[0] = 4'b1110;
    pulse_start(0, acc);
    wait_until(acc + 5);
    start[0] = 1'b1;
    exp_tt[0] = 4'b0000;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, acc, 24, "midrun_done_edge");
    check("midrun_pass", 0, 32'(pass[0]), 32'(1));
    check("midrun_obs", 0, 32'(obs_tt[0]), 32'(4'b1110));
    repeat (3) @(negedge clk);

    // Reset during SETTLE of vector 1, then a fresh run.
    exp_tt[0] = 4'b1110;
    pulse_start(0, acc);
    wait_until(acc + 7);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    check("rst_busy", 0, 32'(busy[0]), 32'(0));
    check("rst_gate", 0, 32'({gate_a[0], gate_b[0]}), 32'(0));
    check("rst_obs", 0, 32'(obs_tt[0]), 32'(0));
    @(negedge clk);
    run_and_check(0, 4'b1110, 24, 4'b1110, 4'b0000, 1'b1, "after_rst");

    // Minimum settle time: done 12 edges after start.
    run_and_check(1, 4'b1110, 12, 4'b1110, 4'b0000, 1'b1, "s1");

    // start and abort together in IDLE: stays idle.
    @(negedge clk);
    start[1] = 1'b1;
    abort[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    abort[1] = 1'b0;
    check("start_abort_busy", 1, 32'(busy[1]), 32'(0));
    @(negedge clk);
    check("start_abort_busy2", 1, 32'(busy[1]), 32'(0));
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
